// File: rtl/cpu_pkg.sv
// cpu_pkg.sv
// Shared arbiter types: FSM states, read owners, tag bundle.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } arb_owner_e;

  typedef struct packed {
    arb_owner_e owner;
    logic       sel;
  } arb_tag_t;

  localparam arb_tag_t TAG_NONE = '{
    owner: OWN_NONE,
    sel:   1'b0
  };

  function automatic logic [7:0] half_be(
    input logic hi
  );
    return hi ? 8'hF0 : 8'h0F;
  endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// arb_tag_pipe.sv
// Fixed-latency owner tag shift register for RAM reads.
module arb_tag_pipe
  import cpu_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  arb_tag_t push_i,
  output arb_tag_t tail_o,
  output logic     empty_o
);

  arb_tag_t stg_q [LAT];

  // shift one tag per cycle; reset drops all in-flight reads
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LAT; i++) begin
        stg_q[i] <= TAG_NONE;
      end
    end else begin
      stg_q[0] <= push_i;
      for (int i = 1; i < LAT; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
    end
  end

  assign tail_o = stg_q[LAT-1];

  // empty once only the retiring tail can still hold a read
  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      if (stg_q[i].owner != OWN_NONE) begin
        empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter.sv
// Shares one unified RAM between loader, data and fetch ports.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [31:0]       ld_data_i,
  input  logic              ld_done_i,
  output logic              ld_gnt_o,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [63:0]       dm_wdata_i,
  input  logic [7:0]        dm_be_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [63:0]       dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  output logic [7:0]        mem_be_o,
  input  logic [63:0]       mem_rdata_i,
  output logic              busy_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  arb_state_e    state_q;
  arb_state_e    state_d;
  logic [CW-1:0] starve_q;
  logic          ld_g;
  logic          if_g;
  logic          dm_g;
  logic          if_first;
  arb_tag_t      push;
  arb_tag_t      tail;
  logic          pipe_empty;
  logic [31:0]   if_word;
  logic [31:0]   if_hold_q;
  logic [63:0]   dm_hold_q;

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // fetch starvation counter, saturating
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (!if_req_i || if_g) begin
      starve_q <= '0;
    end else if (state_q == RUN &&
                 starve_q != SMAX) begin
      starve_q <= starve_q + CW'(1);
    end
  end

  // next state and one-hot grant selection
  always_comb begin
    state_d  = state_q;
    ld_g     = 1'b0;
    if_g     = 1'b0;
    dm_g     = 1'b0;
    if_first = if_req_i &&
               (starve_q == SMAX);
    unique case (state_q)
      BOOT: begin
        ld_g = ld_req_i;
        if (ld_done_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ld_req_i) begin
          state_d = DRAIN;
        end else if (dm_req_i &&
                     !if_first) begin
          dm_g = 1'b1;
        end else if (if_req_i) begin
          if_g = 1'b1;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_d = BOOT;
        end
      end
      default: state_d = BOOT;
    endcase
    if (rst_i) begin
      ld_g = 1'b0;
      if_g = 1'b0;
      dm_g = 1'b0;
    end
  end

  // forward the granted request to the RAM and tag reads
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    push        = TAG_NONE;
    unique case (1'b1)
      ld_g: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = ld_addr_i;
        mem_wdata_o = {ld_data_i, ld_data_i};
        mem_be_o    = half_be(ld_addr_i[2]);
      end
      dm_g: begin
        mem_req_o   = 1'b1;
        mem_we_o    = dm_we_i;
        mem_addr_o  = dm_addr_i;
        mem_wdata_o = dm_wdata_i;
        mem_be_o    = dm_be_i;
        if (!dm_we_i) begin
          push = '{owner: OWN_DM,
                   sel:   dm_addr_i[2]};
        end
      end
      if_g: begin
        mem_req_o  = 1'b1;
        mem_addr_o = if_addr_i;
        mem_be_o   = 8'hFF;
        push       = '{owner: OWN_IF,
                       sel:   if_addr_i[2]};
      end
      default: ;
    endcase
  end

  arb_tag_pipe #(
    .LAT (LAT)
  ) u_tags (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .tail_o  (tail),
    .empty_o (pipe_empty)
  );

  assign if_word = tail.sel ?
                   mem_rdata_i[63:32] :
                   mem_rdata_i[31:0];

  assign if_rvalid_o = !rst_i &&
                       tail.owner == OWN_IF;
  assign dm_rvalid_o = !rst_i &&
                       tail.owner == OWN_DM;

  // keep the last returned data visible between responses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if_hold_q <= '0;
      dm_hold_q <= '0;
    end else begin
      if (if_rvalid_o) begin
        if_hold_q <= if_word;
      end
      if (dm_rvalid_o) begin
        dm_hold_q <= mem_rdata_i;
      end
    end
  end

  assign if_rdata_o = if_rvalid_o ?
                      if_word : if_hold_q;
  assign dm_rdata_o = dm_rvalid_o ?
                      mem_rdata_i : dm_hold_q;

  assign ld_gnt_o   = ld_g;
  assign if_gnt_o   = if_g;
  assign dm_gnt_o   = dm_g;
  assign if_stall_o = if_req_i & ~if_g;
  assign busy_o     = rst_i ||
                      state_q != RUN;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a reference model.
module tb_mem_port_arbiter;

  localparam int AW  = 64;
  localparam int LAT = 2;
  localparam int SM  = 4;

  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          ld_req_i = 1'b0;
  logic [AW-1:0] ld_addr_i = '0;
  logic [31:0]   ld_data_i = '0;
  logic          ld_done_i = 1'b0;
  logic          ld_gnt_o;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [31:0]   if_rdata_o;
  logic          if_stall_o;
  logic          dm_req_i = 1'b0;
  logic          dm_we_i = 1'b0;
  logic [AW-1:0] dm_addr_i = '0;
  logic [63:0]   dm_wdata_i = '0;
  logic [7:0]    dm_be_i = '0;
  logic          dm_gnt_o;
  logic          dm_rvalid_o;
  logic [63:0]   dm_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [63:0]   mem_wdata_o;
  logic [7:0]    mem_be_o;
  logic [63:0]   mem_rdata_i;
  logic          busy_o;

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .LAT        (LAT),
    .STARVE_MAX (SM)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ld_req_i    (ld_req_i),
    .ld_addr_i   (ld_addr_i),
    .ld_data_i   (ld_data_i),
    .ld_done_i   (ld_done_i),
    .ld_gnt_o    (ld_gnt_o),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .if_stall_o  (if_stall_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_be_i     (dm_be_i),
    .dm_gnt_o    (dm_gnt_o),
    .dm_rvalid_o (dm_rvalid_o),
    .dm_rdata_o  (dm_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(
    input logic [63:0] o,
    input logic [63:0] n,
    input logic [7:0]  be
  );
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++)
      if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // RAM environment: fixed LAT read pipe, junk when idle
  logic [63:0] ram [longint unsigned];
  logic [63:0] rpipe [LAT];

  always @(posedge clk_i) begin
    logic [63:0] v;
    longint unsigned k;
    k = longint'(mem_addr_o >> 3);
    v = {$urandom, $urandom};
    if (mem_req_o && mem_we_o) begin
      ram[k] = merge(ram.exists(k) ? ram[k] : 64'h0,
                     mem_wdata_o, mem_be_o);
    end else if (mem_req_o) begin
      v = ram.exists(k) ? ram[k] : 64'h0;
    end
    rpipe[0] <= v;
    for (int i = 1; i < LAT; i++)
      rpipe[i] <= rpipe[i-1];
  end

  assign mem_rdata_i = rpipe[LAT-1];

  // reference model state
  typedef struct {
    int          due;
    bit          own_if;
    logic [63:0] data;
  } resp_t;

  resp_t       pend [$];
  logic [63:0] ref_mem [longint unsigned];
  int          ms = M_BOOT;
  int          starve = 0;
  int          cyc = 0;
  logic [31:0] last_ird = '0;
  logic [63:0] last_drd = '0;

  logic g_ld, g_if, g_dm;
  logic obs_ld, obs_if, obs_dm, obs_stall;
  logic obs_irv, obs_drv, obs_busy, obs_mreq;
  logic obs_mwe;
  logic [7:0]  obs_be;
  logic [31:0] obs_ird;
  logic [63:0] obs_drd;

  function automatic logic [63:0] ref_rd(
    input logic [AW-1:0] a
  );
    longint unsigned k;
    k = longint'(a >> 3);
    return ref_mem.exists(k) ? ref_mem[k] : 64'h0;
  endfunction

  task automatic ref_wr(
    input logic [AW-1:0] a,
    input logic [63:0]   d,
    input logic [7:0]    be
  );
    longint unsigned k;
    k = longint'(a >> 3);
    ref_mem[k] = merge(ref_rd(a), d, be);
  endtask

  // one clock: check outputs at negedge, advance model at posedge
  task automatic step();
    logic e_ld, e_if, e_dm, e_rvi, e_rvd;
    logic e_req, e_we;
    logic [AW-1:0] e_addr;
    logic [63:0]   e_wd, e_drd, rd;
    logic [7:0]    e_be;
    logic [31:0]   e_ird;
    resp_t r;
    @(negedge clk_i);
    e_ld = 1'b0;
    e_if = 1'b0;
    e_dm = 1'b0;
    if (!rst_i) begin
      if (ms == M_BOOT) begin
        e_ld = ld_req_i;
      end else if (ms == M_RUN && !ld_req_i) begin
        if (dm_req_i && !(if_req_i && starve >= SM))
          e_dm = 1'b1;
        else if (if_req_i)
          e_if = 1'b1;
      end
    end
    e_rvi = !rst_i && pend.size() > 0 &&
            pend[0].due == cyc && pend[0].own_if;
    e_rvd = !rst_i && pend.size() > 0 &&
            pend[0].due == cyc && !pend[0].own_if;
    e_ird = e_rvi ? pend[0].data[31:0] : last_ird;
    e_drd = e_rvd ? pend[0].data : last_drd;
    e_req = e_ld | e_if | e_dm;
    e_we  = e_ld | (e_dm & dm_we_i);
    e_addr = e_ld ? ld_addr_i :
             e_dm ? dm_addr_i :
             e_if ? if_addr_i : '0;
    e_wd = e_ld ? {ld_data_i, ld_data_i} :
           e_dm ? dm_wdata_i : 64'h0;
    e_be = e_ld ? (ld_addr_i[2] ? 8'hF0 : 8'h0F) :
           e_dm ? dm_be_i :
           e_if ? 8'hFF : 8'h00;
    chk("ld_gnt", ld_gnt_o, e_ld);
    chk("if_gnt", if_gnt_o, e_if);
    chk("dm_gnt", dm_gnt_o, e_dm);
    chk("if_stall", if_stall_o, if_req_i & ~e_if);
    chk("if_rvalid", if_rvalid_o, e_rvi);
    chk("dm_rvalid", dm_rvalid_o, e_rvd);
    chk("if_rdata", if_rdata_o, e_ird);
    chk("dm_rdata", dm_rdata_o, e_drd);
    chk("mem_req", mem_req_o, e_req);
    chk("mem_we", mem_we_o, e_we);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_wdata", mem_wdata_o, e_wd);
    chk("mem_be", mem_be_o, e_be);
    chk("busy", busy_o, rst_i || ms != M_RUN);
    obs_ld = ld_gnt_o;   obs_if = if_gnt_o;
    obs_dm = dm_gnt_o;   obs_stall = if_stall_o;
    obs_irv = if_rvalid_o; obs_drv = dm_rvalid_o;
    obs_ird = if_rdata_o;  obs_drd = dm_rdata_o;
    obs_be = mem_be_o;   obs_busy = busy_o;
    obs_mreq = mem_req_o; obs_mwe = mem_we_o;
    g_ld = e_ld; g_if = e_if; g_dm = e_dm;
    @(posedge clk_i);
    if (rst_i) begin
      ms = M_BOOT;
      starve = 0;
      pend.delete();
      last_ird = '0;
      last_drd = '0;
    end else begin
      if (e_rvi) begin
        last_ird = e_ird;
        void'(pend.pop_front());
      end
      if (e_rvd) begin
        last_drd = e_drd;
        void'(pend.pop_front());
      end
      if (e_ld)
        ref_wr(ld_addr_i, {ld_data_i, ld_data_i},
               ld_addr_i[2] ? 8'hF0 : 8'h0F);
      if (e_dm && dm_we_i)
        ref_wr(dm_addr_i, dm_wdata_i, dm_be_i);
      if (e_dm && !dm_we_i) begin
        r.due = cyc + LAT;
        r.own_if = 1'b0;
        r.data = ref_rd(dm_addr_i);
        pend.push_back(r);
      end
      if (e_if) begin
        rd = ref_rd(if_addr_i);
        r.due = cyc + LAT;
        r.own_if = 1'b1;
        r.data = {32'h0, if_addr_i[2] ? rd[63:32] : rd[31:0]};
        pend.push_back(r);
      end
      if (!if_req_i || e_if)
        starve = 0;
      else if (ms == M_RUN && starve < SM)
        starve++;
      if (ms == M_BOOT) begin
        if (ld_done_i) ms = M_RUN;
      end else if (ms == M_RUN) begin
        if (ld_req_i) ms = M_DRAIN;
      end else begin
        if (pend.size() == 0) ms = M_BOOT;
      end
    end
    cyc++;
    #1;
  endtask

  logic [31:0] boot_img [4] = '{
    32'h00000013, 32'h00100093,
    32'h00200113, 32'h00300193
  };

  int ld_left = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    int cnt;
    int got;
    repeat (2) @(posedge clk_i);
    #1;
    step();
    step();
    rst_i = 1'b0;
    step();
    chk("rst_busy", obs_busy, 1'b1);
    chk("rst_mem_req", obs_mreq, 1'b0);

    // boot: four loader writes with fetch pending
    if_req_i = 1'b1;
    if_addr_i = 64'h4;
    for (int k = 0; k < 4; k++) begin
      ld_req_i = 1'b1;
      ld_addr_i = 64'(k * 4);
      ld_data_i = boot_img[k];
      step();
      chk("boot_ld_gnt", obs_ld, 1'b1);
      chk("boot_if_gnt", obs_if, 1'b0);
      chk("boot_be", obs_be,
          (k % 2 == 1) ? 8'hF0 : 8'h0F);
    end
    ld_req_i = 1'b0;
    ld_done_i = 1'b1;
    step();
    ld_done_i = 1'b0;
    step();
    chk("boot_fetch_gnt", obs_if, 1'b1);
    if_req_i = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      step();
      if (i == LAT) begin
        chk("boot_fetch_rv", obs_irv, 1'b1);
        chk("boot_fetch_data", obs_ird, 32'h00100093);
      end
    end

    // priority and starvation
    dm_req_i = 1'b1;
    dm_we_i = 1'b0;
    dm_addr_i = 64'h8;
    dm_be_i = 8'hFF;
    if_req_i = 1'b1;
    if_addr_i = 64'h8;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 4) begin
        chk("starve_dm", obs_dm, 1'b1);
        chk("starve_stall", obs_stall, 1'b1);
      end else begin
        chk("starve_if", obs_if, 1'b1);
        chk("starve_dm_off", obs_dm, 1'b0);
      end
    end
    step();
    chk("starve_clear", obs_dm, 1'b1);
    dm_req_i = 1'b0;
    if_req_i = 1'b0;
    repeat (LAT + 1) step();

    // mixed: write then read back
    dm_req_i = 1'b1;
    dm_we_i = 1'b1;
    dm_addr_i = 64'h40;
    dm_wdata_i = 64'hDEADBEEF_CAFEF00D;
    dm_be_i = 8'hFF;
    step();
    chk("mix_wr_gnt", obs_dm, 1'b1);
    chk("mix_wr_we", obs_mwe, 1'b1);
    dm_we_i = 1'b0;
    step();
    chk("mix_rd_gnt", obs_dm, 1'b1);
    dm_req_i = 1'b0;
    cnt = 0;
    for (int i = 1; i <= LAT + 2; i++) begin
      step();
      if (obs_drv) cnt++;
      if (i == LAT) chk("mix_rv_at_lat", obs_drv, 1'b1);
    end
    chk("mix_rv_cnt", cnt, 1);
    chk("mix_data", obs_drd, 64'hDEADBEEF_CAFEF00D);

    // drain: two fetches in flight, then loader asks
    if_req_i = 1'b1;
    if_addr_i = 64'h0;
    step();
    chk("drain_f0", obs_if, 1'b1);
    if_addr_i = 64'h4;
    step();
    chk("drain_f1", obs_if, 1'b1);
    if_addr_i = 64'h8;
    dm_req_i = 1'b1;
    dm_addr_i = 64'h40;
    ld_req_i = 1'b1;
    ld_addr_i = 64'h10;
    ld_data_i = 32'h00400213;
    cnt = 0;
    got = -1;
    for (int i = 0; i < 8 && got < 0; i++) begin
      step();
      if (obs_irv) cnt++;
      if (obs_ld) got = i;
      else begin
        chk("drain_no_dm", obs_dm, 1'b0);
        chk("drain_no_if", obs_if, 1'b0);
      end
    end
    chk("drain_ld_cycle", got, 2);
    chk("drain_rv_cnt", cnt, 2);
    ld_req_i = 1'b0;
    ld_done_i = 1'b1;
    step();
    ld_done_i = 1'b0;
    step();
    chk("drain_run_dm", obs_dm, 1'b1);
    dm_req_i = 1'b0;
    if_req_i = 1'b0;
    repeat (LAT + 1) step();

    // reset with a data read in flight
    dm_req_i = 1'b1;
    dm_we_i = 1'b0;
    dm_addr_i = 64'h40;
    step();
    chk("rst_rd_gnt", obs_dm, 1'b1);
    dm_req_i = 1'b0;
    rst_i = 1'b1;
    step();
    chk("rst_mid_rv", obs_drv, 1'b0);
    rst_i = 1'b0;
    cnt = 0;
    for (int i = 0; i <= LAT; i++) begin
      step();
      if (obs_drv) cnt++;
    end
    chk("rst_no_rv", cnt, 0);
    chk("rst_boot_busy", obs_busy, 1'b1);
    chk("rst_idle_req", obs_mreq, 1'b0);
    chk("rst_rdata", obs_drd, 64'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_i = ($urandom_range(0, 299) == 0);
      ld_done_i = 1'b0;
      if (!dm_req_i || g_dm) begin
        dm_req_i = ($urandom_range(0, 99) < 45);
        dm_we_i = $urandom_range(0, 1) == 1;
        dm_addr_i = 64'($urandom_range(0, 31)) << 3;
        dm_wdata_i = {$urandom, $urandom};
        dm_be_i = 8'($urandom);
      end
      if (!if_req_i || g_if) begin
        if_req_i = ($urandom_range(0, 99) < 60);
        if_addr_i = 64'($urandom_range(0, 63)) << 2;
      end
      if (g_ld) begin
        ld_left--;
        if (ld_left <= 0) begin
          ld_left = 0;
          ld_req_i = 1'b0;
        end else begin
          ld_addr_i = 64'($urandom_range(0, 63)) << 2;
          ld_data_i = $urandom;
        end
      end
      if (ms == M_BOOT) begin
        if (ld_left == 0)
          ld_done_i = 1'b1;
        else if (ld_left == 1 && $urandom_range(0, 1) == 1)
          ld_done_i = 1'b1;
      end else if (ms == M_RUN && !ld_req_i &&
                   $urandom_range(0, 63) == 0) begin
        ld_req_i = 1'b1;
        ld_left = $urandom_range(1, 4);
        ld_addr_i = 64'($urandom_range(0, 63)) << 2;
        ld_data_i = $urandom;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and sequencer for the CPU. It shares one unified instruction/data RAM between three requesters: the boot-time instruction loader (`wr_instr` path), the Memory-stage data port and the InstructionFetch port. It owns the boot/run/drain sequencing, tracks fixed-latency reads back to their owner, and raises a fetch stall to the pipeline whenever fetch loses arbitration.

## Interface
- `ADDR_W`, 64, byte address width.
- `LAT`, 1, fixed RAM read latency in cycles (≥1).
- `STARVE_MAX`, 4, consecutive denied fetch cycles before fetch outranks data.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `ld_req_i` in 1: loader write request.
- `ld_addr_i` in ADDR_W: loader byte address (word-aligned).
- `ld_data_i` in 32: loader instruction word.
- `ld_done_i` in 1: loader finished (single-cycle pulse).
- `ld_gnt_o` out 1: loader write accepted this cycle.
- `if_req_i` in 1: fetch read request.
- `if_addr_i` in ADDR_W: fetch byte address.
- `if_gnt_o` out 1: fetch accepted.
- `if_rvalid_o` out 1: fetch data valid.
- `if_rdata_o` out 32: instruction word.
- `if_stall_o` out 1: `if_req_i & ~if_gnt_o`.
- `dm_req_i` in 1: data request.
- `dm_we_i` in 1: data write.
- `dm_addr_i` in ADDR_W: data address.
- `dm_wdata_i` in 64: data write data.
- `dm_be_i` in 8: byte enables.
- `dm_gnt_o` out 1: data accepted.
- `dm_rvalid_o` out 1: data read valid.
- `dm_rdata_o` out 64: read data.
- `mem_req_o`, `mem_we_o` out 1: RAM access strobe and write.
- `mem_addr_o` out ADDR_W: RAM address.
- `mem_wdata_o` out 64: RAM write data.
- `mem_be_o` out 8: RAM byte enables.
- `mem_rdata_i` in 64: RAM read data, valid exactly LAT cycles after the read strobe.
- `busy_o` out 1: state ≠ RUN.

## Operation
- FSM states: BOOT, RUN, DRAIN. Reset enters BOOT.
- BOOT:
  - Only the loader is granted; `if_gnt_o` and `dm_gnt_o` are 0.
  - `ld_done_i` moves to RUN the next cycle.
  - `ld_req_i` and `ld_done_i` asserted together: the write is granted, then the FSM moves to RUN.
- RUN: at most one grant per cycle. Priority order:
  - `ld_req_i` first. Not granted in RUN; it moves the FSM to DRAIN.
  - Data next.
  - Fetch last, except when `starve_cnt == STARVE_MAX`: fetch then outranks data.
- DRAIN:
  - No new grants.
  - Moves to BOOT once no reads are in flight (tag pipeline empty). If the pipeline is already empty, that happens the next cycle.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each RUN cycle with `if_req_i & ~if_gnt_o`.
  - Clears on `if_gnt_o`, and on any cycle where `if_req_i` is low.
- Grants are combinational from the current requests and state; the address and data are forwarded to `mem_*` in the same cycle.
- Loader writes:
  - `mem_we_o`=1.
  - `mem_wdata_o` = `{ld_data_i, ld_data_i}`.
  - `mem_be_o` = `ld_addr_i[2] ? 8'hF0 : 8'h0F`.
- Fetch reads: `mem_be_o`=8'hFF. Returned word is `mem_rdata_i[63:32]` if the latched `addr[2]` is 1, else `[31:0]`.
- Reads push an owner tag (NONE/IF/DM) plus `addr[2]` into an LAT-deep shift pipeline. At the tail, exactly one of `if_rvalid_o`/`dm_rvalid_o` pulses with the data.
- Writes (data or loader) push NONE and produce no response.

## Timing
- Reset values:
  - All grants, `rvalid` outputs and `mem_req_o`/`mem_we_o` are 0.
  - Data and address outputs are 0.
  - `busy_o`=1 (BOOT).
  - `starve_cnt`=0; tag pipeline all NONE.
- Read latency: `rvalid` pulses exactly LAT cycles after the grant cycle. Fully pipelined, one per cycle.
- Reset mid-operation: in-flight reads are discarded and no `rvalid` is issued for them.
- Requesters hold `req`/`addr`/`data` until granted. A deasserted request is never granted.
- `if_rdata_o` and `dm_rdata_o` are valid only while their `rvalid` is high. Otherwise they hold their last value.

## Structure
- Shared in `cpu_pkg`:
  - `arb_state_e` {BOOT, RUN, DRAIN}.
  - `arb_owner_e` {OWN_NONE, OWN_IF, OWN_DM}.
  - The tag struct (owner, word select).
- One sub-module, `arb_tag_pipe`: parameterized LAT-deep tag shift register with synchronous clear and an empty flag.

## Test plan
- **Boot:**
  - After reset, stimulus:
    - 4 loader writes to 0x0, 0x4, 0x8, 0xC with data 0x00000013, 0x00100093, 0x00200113, 0x00300193;
    - `if_req_i`=1 throughout.
  - Required response:
    - `ld_gnt_o`=1 on each write and `if_gnt_o`=0;
    - `mem_be_o` alternates 0F/F0;
    - `ld_done_i` → RUN next cycle, after which fetch of 0x4 returns 0x00100093 LAT cycles later.
- **Priority and starvation:**
  - Stimulus: in RUN, `dm_req_i` and `if_req_i` held high continuously (STARVE_MAX=4).
  - Required response:
    - data granted for 4 cycles with `if_stall_o`=1;
    - then fetch granted on cycle 5 and the counter clears.
- **Mixed traffic:**
  - Stimulus: data write 0xDEADBEEF_CAFEF00D to 0x40 with BE=FF, then data read of 0x40.
  - Required response:
    - `dm_rvalid_o` pulses once, LAT cycles after the read grant, with the same value;
    - no `rvalid` is produced for the write.
- **Drain:**
  - Stimulus: with LAT=2, back-to-back fetch reads in flight, then `ld_req_i` asserts.
  - Required response:
    - in-flight reads still return;
    - no grants while in DRAIN;
    - BOOT is entered on the cycle after the last `rvalid`, and the loader is granted in BOOT.
- **Reset mid-flight:**
  - Stimulus: `rst_i` asserted in the cycle after a data read grant.
  - Required response: no `dm_rvalid_o`, all outputs at their reset values, state BOOT.
